// File: rtl/bus_arbiter4_pkg.sv
// Shared constants and types for the four-requester round-robin bus arbiter.
package bus_arbiter4_pkg;

    localparam int unsigned ARB_PORTS = 4;
    localparam int unsigned ARB_SEL_W = 2;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic logic [ARB_PORTS-1:0] onehot4(input logic [ARB_SEL_W-1:0] idx);
        logic [ARB_PORTS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational rotate-priority picker: first set request scanning upward from start, with wrap.
module bus_arbiter4_rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [ARB_PORTS-1:0] req_i,
    input  logic [ARB_SEL_W-1:0] start_i,
    output logic                 found_o,
    output logic [ARB_SEL_W-1:0] idx_o
);

    logic [ARB_SEL_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < ARB_PORTS; i++) begin
            cand = start_i + ARB_SEL_W'(i);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter with burst locking; drives the downstream mux select.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ARB_PORTS-1:0] req,
    input  logic [ARB_PORTS-1:0] last,
    input  logic                 ack,
    output logic [ARB_PORTS-1:0] gnt,
    output logic [ARB_SEL_W-1:0] sel,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned CntW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BEATS - 1);

    arb_state_t           state_q, state_d;
    logic [ARB_PORTS-1:0] gnt_q, gnt_d;
    logic [ARB_SEL_W-1:0] sel_q, sel_d;
    logic [ARB_SEL_W-1:0] last_winner_q, last_winner_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic                 pick_found;
    logic [ARB_SEL_W-1:0] pick_idx;
    logic [ARB_SEL_W-1:0] pick_start;

    assign pick_start = last_winner_q + ARB_SEL_W'(1);

    bus_arbiter4_rr_pick4 u_pick (
        .req_i   (req),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        last_winner_d = last_winner_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    gnt_d   = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                // Release covers abandon, final beat and forced release; sel holds for mux stability.
                if (!req[sel_q] || (ack && (last[sel_q] || cnt_q == CntMax))) begin
                    state_d       = ARB_IDLE;
                    gnt_d         = '0;
                    cnt_d         = '0;
                    last_winner_d = sel_q;
                    timeout_d     = req[sel_q] && !last[sel_q];
                end else if (ack) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            gnt_q         <= '0;
            sel_q         <= '0;
            last_winner_q <= ARB_SEL_W'(ARB_PORTS - 1);
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            sel_q         <= sel_d;
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == ARB_GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 with a cycle model and an exhaustive picker sweep.
module tb_bus_arbiter4;

    localparam int unsigned MAXB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req, last;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy, timeout;

    logic [3:0] p_req;
    logic [1:0] p_start;
    logic       p_found;
    logic [1:0] p_idx;

    int nchecks = 0;
    int nerrors = 0;

    bus_arbiter4 #(.MAX_BEATS(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .last    (last),
        .ack     (ack),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    bus_arbiter4_rr_pick4 u_pick (
        .req_i   (p_req),
        .start_i (p_start),
        .found_o (p_found),
        .idx_o   (p_idx)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, how many beats it has had, who won last.
    logic m_busy = 1'b0;
    int   m_owner = 0;
    int   m_lw = 3;
    int   m_beats = 0;
    logic m_to = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_lw    <= 3;
            m_beats <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    for (int k = 4; k >= 1; k--) begin
                        if (req[(m_lw + k) % 4]) m_owner <= (m_lw + k) % 4;
                    end
                    m_busy  <= 1'b1;
                    m_beats <= 0;
                end
            end else if (!req[m_owner]) begin
                m_busy  <= 1'b0;
                m_lw    <= m_owner;
                m_beats <= 0;
            end else if (ack) begin
                if (last[m_owner] || (m_beats + 1 == MAXB)) begin
                    m_busy  <= 1'b0;
                    m_lw    <= m_owner;
                    m_beats <= 0;
                    m_to    <= !last[m_owner];
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("model_gnt", 32'(gnt), m_busy ? 32'(1 << m_owner) : 32'd0);
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_timeout", 32'(timeout), 32'(m_to));
        if (m_busy) check("model_sel", 32'(sel), 32'(m_owner));
    endtask

    logic [3:0] rr_exp [6];
    int         exp_idx;
    logic       exp_found;

    initial begin
        reset_n = 1'b0;
        req = 4'b1111;
        last = 4'b0000;
        ack = 1'b0;

        // Exhaustive picker sweep.
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 16; r++) begin
                p_start = 2'(s);
                p_req = 4'(r);
                #1;
                exp_found = 1'b0;
                exp_idx = 0;
                for (int k = 3; k >= 0; k--) begin
                    if (p_req[(s + k) % 4]) begin
                        exp_found = 1'b1;
                        exp_idx = (s + k) % 4;
                    end
                end
                check("pick_found", 32'(p_found), 32'(exp_found));
                if (exp_found) check("pick_idx", 32'(p_idx), 32'(exp_idx));
            end
        end

        // Reset and first grant.
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_sel", 32'(sel), 32'h0);
        check("first_busy", 32'(busy), 32'h1);

        // Round robin with single-beat bursts.
        last = 4'b1111;
        ack = 1'b1;
        rr_exp = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
        end
        req = 4'b0000;
        tick();
        check("rr_drop_busy", 32'(busy), 32'h0);

        // Burst hold: three beats for requester 0, then requester 2.
        req = 4'b0101;
        last = 4'b0000;
        ack = 1'b0;
        tick();
        check("burst_gnt0", 32'(gnt), 32'h1);
        ack = 1'b1;
        tick();
        check("burst_gnt1", 32'(gnt), 32'h1);
        tick();
        check("burst_gnt2", 32'(gnt), 32'h1);
        last = 4'b0001;
        tick();
        check("burst_bubble", 32'(gnt), 32'h0);
        last = 4'b0000;
        ack = 1'b0;
        tick();
        check("burst_next_gnt", 32'(gnt), 32'h4);
        check("burst_next_sel", 32'(sel), 32'h2);

        // Timeout after MAX_BEATS beats with no last.
        req = 4'b0011;
        ack = 1'b1;
        tick();
        check("to_abandon2", 32'(gnt), 32'h0);
        tick();
        check("to_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold", 32'(gnt), 32'h1);
            check("to_no_pulse", 32'(timeout), 32'h0);
        end
        tick();
        check("to_release", 32'(gnt), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_next_gnt", 32'(gnt), 32'h2);
        check("to_pulse_end", 32'(timeout), 32'h0);

        // Abandon by requester 1.
        req = 4'b0100;
        ack = 1'b0;
        tick();
        check("ab_gnt", 32'(gnt), 32'h0);
        check("ab_timeout", 32'(timeout), 32'h0);
        tick();
        check("ab_next_gnt", 32'(gnt), 32'h4);

        // Async reset in the middle of a grant to requester 3.
        req = 4'b1000;
        tick();
        tick();
        check("ar_pre_gnt", 32'(gnt), 32'h8);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        req = 4'b1010;
        #1;
        reset_n = 1'b1;
        tick();
        check("ar_first_gnt", 32'(gnt), 32'h2);

        // last coinciding with the beat limit: ordinary release, no timeout.
        ack = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("lim_hold", 32'(gnt), 32'h2);
        last = 4'b0010;
        tick();
        check("lim_release", 32'(gnt), 32'h0);
        check("lim_no_timeout", 32'(timeout), 32'h0);
        last = 4'b0000;
        ack = 1'b0;
        tick();
        check("lim_next_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_sel_hold", 32'(sel), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Four-requester round-robin bus arbiter with burst locking.
- Sits directly upstream of the existing 4-input operand/bus multiplexer: drives its 2-bit select and returns one-hot grants to the requesters.
- Holds the grant for a multi-beat burst until the requester signals its last beat, drops its request, or hits a beat limit.

Parameters:
- MAX_BEATS, 16: maximum accepted beats per grant before forced release; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i = requester i.
- last  input  4  bit i marks the current beat of requester i as its final beat.
- ack  input  1  downstream consumer accepts the current beat.
- gnt  output  4  one-hot grant; all-zero when no grant is held.
- sel  output  2  binary index of the granted requester; feeds the mux select.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_BEATS.

Behaviour:
- Reset (async assert, sync deassert by the system): gnt=0, sel=0, busy=0, timeout=0, beat count=0, last_winner=3, so the first arbitration favours requester 0. Reset mid-burst clears all state immediately, with no clock edge needed.
- States: IDLE and GRANT, all registered. There are no combinational paths from inputs to gnt or sel.
- IDLE:
  - If req != 0, select the first set bit scanning upward from (last_winner+1) mod 4 with wrap.
  - On the next edge: gnt=onehot(winner), sel=winner, busy=1, count=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE. gnt=0 and sel holds its previous value, so the mux output stays stable.
  - ack is ignored in IDLE.
- GRANT:
  - A beat completes on a cycle where ack=1 and req[sel]=1.
  - On a completed beat with last[sel]=1: release.
  - On a completed beat with last[sel]=0 and count==MAX_BEATS-1: release and pulse timeout=1 for exactly the next cycle.
  - On any other completed beat: count increments.
  - If req[sel]=0 (requester abandons): release with no timeout, whether or not ack is high.
  - last bits and req bits of non-granted requesters have no effect while in GRANT.
- Release, taken on the next edge:
  - last_winner=sel, gnt=0, busy=0, count=0, state=IDLE. sel holds its value.
  - Re-arbitration happens in the following IDLE cycle, giving one bubble cycle between grants.
- Simultaneous cases:
  - last and the limit on the same beat: treat as a normal last release, no timeout.
  - MAX_BEATS=1: every beat releases; timeout pulses only when last=0.
- Count width is clog2(MAX_BEATS) bits, minimum 1. Count never exceeds MAX_BEATS-1, so there is no wrap.
- Invariants:
  - gnt is one-hot or zero.
  - gnt != 0 if and only if busy.
  - When busy, gnt == onehot(sel).

Decomposition:
- Shared constants package:
  - ARB_PORTS=4.
  - ARB_SEL_W=2.
  - The state enum arb_state_t {ARB_IDLE, ARB_GRANT}.
- One natural sub-module: _rr_pick4, a purely combinational rotate-priority picker.
  - Inputs: req[3:0], start[1:0].
  - Outputs: found, idx[1:0].
  - Unit-tested separately with an exhaustive 64-combination sweep.

Test Plan:
- Reset/first grant: reset_n low with req=1111 -> gnt=0000, sel=00, busy=0. Release reset -> after one edge gnt=0001, sel=00, busy=1.
- Round-robin: req=1111 held, last=1111, ack=1 each GRANT cycle -> gnt sequence 0001, 0100 is wrong; required sequence is 0001, 0010, 0100, 1000, 0001, with a gnt=0000 bubble cycle between each.
- Burst hold: req=0101, requester 0 sends 3 acked beats with last on the third -> gnt=0001 for all three, then one idle cycle, then gnt=0100, sel=10.
- Timeout: MAX_BEATS=4, req=0011, last=0, ack=1 continuously -> release after the 4th beat, timeout=1 for one cycle, next gnt=0010.
- Abandon: gnt=0010, then req1 drops with req=0100 -> next cycle gnt=0000 and timeout=0, following cycle gnt=0100.
- Async reset mid-burst: pulse reset_n low between clock edges during gnt=1000 -> gnt=0000 and busy=0 immediately. After release with req=1010, the first grant is 0010, because last_winner was reset to 3.
